// File: rtl/wb_pkg.sv
// Shared definitions for the store write buffer: entry layout, field widths and sizing helpers.
package wb_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int WORD_AW   = 30;
  localparam int BE_W      = 4;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [WORD_AW-1:0] waddr;
    logic [BE_W-1:0]    byteen;
    logic [DATA_W-1:0]  wd;
  } wb_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Lanes enabled in be take new_wd; the remaining lanes keep old_wd.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_wd,
                                                    input logic [DATA_W-1:0] new_wd,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_wd;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[8*b +: 8] = new_wd[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_hit_detect.sv
// Parallel word-address comparator over the valid buffer entries: load-hit detection
// for the stall logic and tail-entry match for store coalescing.
module wb_hit_detect
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [DEPTH-1:0][WORD_AW-1:0] waddr,
  input  logic [DEPTH-1:0]              valid,
  input  logic                          ld_valid,
  input  logic [WORD_AW-1:0]            ld_waddr,
  input  logic [ptr_w(DEPTH)-1:0]       tail_idx,
  input  logic [WORD_AW-1:0]            st_waddr,
  output logic                          ld_hit,
  output logic                          tail_match
);

  logic [DEPTH-1:0] match;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (waddr[i] == ld_waddr);
    end
  end

  assign ld_hit     = ld_valid && (|match);
  assign tail_match = valid[tail_idx] && (waddr[tail_idx] == st_waddr);

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer between the byte-enable stage and data memory: circular FIFO of aligned
// stores drained to a ready/valid memory port. Define WB_COALESCE_EN to merge same-word stores.
module store_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [31:0]            st_addr,
  input  logic [3:0]             st_byteen,
  input  logic [31:0]            st_wd,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_addr,
  output logic                   stall,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [3:0]             mem_byteen,
  output logic [31:0]            mem_wd,
  input  logic                   mem_ready,
  output logic                   empty,
  output logic [ptr_w(DEPTH):0]  count
);

  localparam int             PW       = ptr_w(DEPTH);
  localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

  wb_entry_t [DEPTH-1:0]          ent_q;
  logic [PW-1:0]                  head;
  logic [PW-1:0]                  tail;
  logic [PW-1:0]                  tail_idx;
  logic [DEPTH-1:0]               valid;
  logic [DEPTH-1:0][WORD_AW-1:0]  waddr_vec;
  logic [WORD_AW-1:0]             st_waddr;
  logic                           st_req;
  logic                           drain;
  logic                           accept;
  logic                           push;
  logic                           merge;
  logic                           ld_hit;
  logic                           tail_match;
  logic                           unused_addr_bits;

  assign st_waddr         = st_addr[31:2];
  assign tail_idx         = tail - PW'(1);
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // An entry is valid when its distance from head (mod DEPTH) is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      waddr_vec[i] = ent_q[i].waddr;
      valid[i]     = {1'b0, PW'(i) - head} < count;
    end
  end

  wb_hit_detect #(
    .DEPTH (DEPTH)
  ) u_hit (
    .waddr      (waddr_vec),
    .valid      (valid),
    .ld_valid   (ld_valid),
    .ld_waddr   (ld_addr[31:2]),
    .tail_idx   (tail_idx),
    .st_waddr   (st_waddr),
    .ld_hit     (ld_hit),
    .tail_match (tail_match)
  );

  assign mem_we     = (count != '0);
  assign empty      = (count == '0);
  assign mem_addr   = {ent_q[head].waddr, 2'b00};
  assign mem_byteen = ent_q[head].byteen;
  assign mem_wd     = ent_q[head].wd;

  assign drain  = mem_we && mem_ready;
  assign st_req = st_valid && (st_byteen != '0);
  assign accept = st_req && ((count < FULL_CNT) || drain);

`ifdef WB_COALESCE_EN
  // Merge only into a tail entry that stays resident across this edge.
  assign merge = accept && (count != '0) && tail_match && !(drain && (tail_idx == head));
`else
  logic unused_tail_match;
  assign unused_tail_match = tail_match;
  assign merge             = 1'b0;
`endif

  assign push  = accept && !merge;
  assign stall = (st_req && !accept) || ld_hit;

  // NOTE: entries are reset too, so mem_* read zero out of reset rather than stale data.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ent_q[tail] <= wb_entry_t'{waddr: st_waddr, byteen: st_byteen, wd: st_wd};
        tail        <= tail + PW'(1);
      end
`ifdef WB_COALESCE_EN
      if (merge) begin
        ent_q[tail_idx].byteen <= ent_q[tail_idx].byteen | st_byteen;
        ent_q[tail_idx].wd     <= merge_lanes(ent_q[tail_idx].wd, st_wd, st_byteen);
      end
`endif
      if (drain) head <= head + PW'(1);
      case ({push, drain})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          st_valid;
  logic [31:0]   st_addr;
  logic [3:0]    st_byteen;
  logic [31:0]   st_wd;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          stall;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_byteen;
  logic [31:0]   mem_wd;
  logic          mem_ready;
  logic          empty;
  logic [CW-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_byteen  (st_byteen),
    .st_wd      (st_wd),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .stall      (stall),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_wd     (mem_wd),
    .mem_ready  (mem_ready),
    .empty      (empty),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending stores, oldest first.
  typedef struct {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] wd;
  } ent_t;
  ent_t mq[$];

  function automatic bit m_drain();
    return (mq.size() != 0) && mem_ready;
  endfunction

  function automatic bit m_accept();
    return st_valid && (st_byteen != 4'd0) && ((mq.size() < DEPTH) || m_drain());
  endfunction

  function automatic bit m_hit();
    if (!ld_valid) return 1'b0;
    foreach (mq[i]) if (mq[i].waddr == ld_addr[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return (st_valid && (st_byteen != 4'd0) && !m_accept()) || m_hit();
  endfunction

  function automatic bit m_merge();
    return COAL && m_accept() && (mq.size() >= 1) && (mq[mq.size()-1].waddr == st_addr[31:2])
           && !(m_drain() && (mq.size() == 1));
  endfunction

  task automatic model_step();
    bit dr, ac, mg;
    int last;
    ent_t e;
    dr = m_drain();
    ac = m_accept();
    mg = m_merge();
    if (mg) begin
      last = mq.size() - 1;
      for (int b = 0; b < 4; b++)
        if (st_byteen[b]) mq[last].wd[8*b +: 8] = st_wd[8*b +: 8];
      mq[last].be = mq[last].be | st_byteen;
    end
    if (dr) void'(mq.pop_front());
    if (ac && !mg) begin
      e.waddr = st_addr[31:2];
      e.be    = st_byteen;
      e.wd    = st_wd;
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic v, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
    st_valid  = v;
    st_addr   = a;
    st_byteen = be;
    st_wd     = wd;
  endtask

  task automatic idle();
    set_store(1'b0, 32'd0, 4'd0, 32'd0);
    ld_valid = 1'b0;
    ld_addr  = 32'd0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    idle();
    @(posedge clk);
    #1;
    n_tests++; if (count !== '0)      begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_tests++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_tests++; if (mem_we !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    n_tests++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_tests++; if (mem_byteen !== 4'd0) begin n_fail++; $display("FAIL reset_mem_byteen: got %h expected 0", mem_byteen); end
    n_tests++; if (mem_wd !== 32'd0)  begin n_fail++; $display("FAIL reset_mem_wd: got %h expected 0", mem_wd); end
    n_tests++; if (stall !== 1'b0)    begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic test_single();
    mem_ready = 1'b1;
    set_store(1'b1, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF);
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL single_stall: got %b expected 0", stall); end
    tick();
    idle();
    #1;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL single_mem_we: got %b expected 1", mem_we); end
    n_tests++; if (mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL single_mem_addr: got %h expected 00001000", mem_addr); end
    n_tests++; if (mem_wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_mem_wd: got %h expected deadbeef", mem_wd); end
    n_tests++; if (mem_byteen !== 4'hF) begin n_fail++; $display("FAIL single_mem_byteen: got %h expected f", mem_byteen); end
    tick();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", empty); end
  endtask

  task automatic test_fill();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i));
      #1;
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fill_stall_%0d: got %b expected 0", i, stall); end
      tick();
    end
    n_tests++; if (count !== CW'(4)) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
    set_store(1'b1, 32'h10, 4'hF, 32'hA000_0004);
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fill_full_stall: got %b expected 1", stall); end
    tick();
    n_tests++; if (count !== CW'(4)) begin n_fail++; $display("FAIL fill_held_count: got %0d expected 4", count); end
    mem_ready = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fill_drain_accept_stall: got %b expected 0", stall); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL fill_first_addr: got %h expected 0", mem_addr); end
    tick();
    idle();
    n_tests++; if (count !== CW'(4)) begin n_fail++; $display("FAIL fill_swap_count: got %0d expected 4", count); end
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_tests++; if (mem_addr !== 32'(4*i)) begin n_fail++; $display("FAIL fill_order_%0d: got %h expected %h", i, mem_addr, 32'(4*i)); end
      n_tests++; if (mem_wd !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL fill_data_%0d: got %h expected %h", i, mem_wd, 32'hA000_0000 + 32'(i)); end
      tick();
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %b expected 1", empty); end
  endtask

  task automatic test_load_hit();
    mem_ready = 1'b0;
    set_store(1'b1, 32'h20, 4'hF, 32'h1234_5678);
    tick();
    idle();
    ld_valid = 1'b1;
    ld_addr  = 32'h22;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hit_stall: got %b expected 1", stall); end
    tick();
    mem_ready = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hit_drain_cycle_stall: got %b expected 1", stall); end
    tick();
    mem_ready = 1'b0;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hit_release_stall: got %b expected 0", stall); end
    ld_valid = 1'b0;
    set_store(1'b1, 32'h20, 4'hF, 32'h1234_5678);
    tick();
    idle();
    ld_valid = 1'b1;
    ld_addr  = 32'h24;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL miss_stall: got %b expected 0", stall); end
    idle();
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_zero_byteen();
    mem_ready = 1'b0;
    set_store(1'b1, 32'h30, 4'hF, 32'h5555_5555);
    tick();
    set_store(1'b1, 32'h34, 4'h0, 32'h6666_6666);
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_be_stall: got %b expected 0", stall); end
    tick();
    idle();
    n_tests++; if (count !== CW'(1)) begin n_fail++; $display("FAIL zero_be_count: got %0d expected 1", count); end
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_coalesce();
    logic [CW-1:0] exp_cnt;
    logic [3:0]    exp_be;
    logic [15:0]   exp_lo;
    exp_cnt = COAL ? CW'(1) : CW'(2);
    exp_be  = COAL ? 4'b0011 : 4'b0001;
    exp_lo  = COAL ? 16'hBBAA : 16'h00AA;
    mem_ready = 1'b0;
    set_store(1'b1, 32'h40, 4'b0001, 32'h0000_00AA);
    tick();
    set_store(1'b1, 32'h41, 4'b0010, 32'h0000_BB00);
    tick();
    idle();
    #1;
    n_tests++; if (count !== exp_cnt) begin n_fail++; $display("FAIL coal_count: got %0d expected %0d", count, exp_cnt); end
    n_tests++; if (mem_byteen !== exp_be) begin n_fail++; $display("FAIL coal_byteen: got %b expected %b", mem_byteen, exp_be); end
    n_tests++; if (mem_wd[15:0] !== exp_lo) begin n_fail++; $display("FAIL coal_wd: got %h expected %h", mem_wd[15:0], exp_lo); end
    mem_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      st_valid  = ($urandom_range(0, 3) != 0);
      st_addr   = 32'h400 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      st_byteen = 4'($urandom_range(0, 15));
      st_wd     = $urandom;
      ld_valid  = ($urandom_range(0, 2) == 0);
      ld_addr   = 32'h400 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      mem_ready = ($urandom_range(0, 1) == 1);
      #1;
      n_tests++; if (stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b expected %b", c, stall, m_stall()); end
      n_tests++; if (count !== CW'(mq.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count, mq.size()); end
      n_tests++; if (mem_we !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_mem_we c%0d: got %b expected %b", c, mem_we, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_tests++; if (mem_addr !== {mq[0].waddr, 2'b00}) begin n_fail++; $display("FAIL rnd_mem_addr c%0d: got %h expected %h", c, mem_addr, {mq[0].waddr, 2'b00}); end
        n_tests++; if (mem_byteen !== mq[0].be) begin n_fail++; $display("FAIL rnd_mem_byteen c%0d: got %h expected %h", c, mem_byteen, mq[0].be); end
        n_tests++; if (mem_wd !== mq[0].wd) begin n_fail++; $display("FAIL rnd_mem_wd c%0d: got %h expected %h", c, mem_wd, mq[0].wd); end
      end
      tick();
    end
    idle();
    mem_ready = 1'b1;
    for (int c = 0; c < DEPTH; c++) tick();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rnd_final_empty: got %b expected 1", empty); end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'h80 + 32'(4*i), 4'hF, 32'hC0DE_0000 + 32'(i));
      tick();
    end
    idle();
    mem_ready = 1'b1;
    #1;
    n_tests++; if (count !== CW'(3)) begin n_fail++; $display("FAIL rmid_pre_count: got %0d expected 3", count); end
    #1;
    reset = 1'b1;
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_we: got %b expected 0", mem_we); end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", count); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_post_we_%0d: got %b expected 0", i, mem_we); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_load_hit();
    test_zero_byteen();
    test_coalesce();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
